// File: rtl/tff_counter_param.sv
// Parametrised toggle flip-flop bank that doubles as a modulo up/down counter.
// Sync load and enable, true/complement outputs, registered terminal-count pulse.
module tff_counter_param #(
    parameter int     WIDTH     = 4,
    parameter longint MODULUS   = 16,
    parameter longint RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc
);

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("tff_counter_param: WIDTH out of range 1..32");
        end
        if (MODULUS < 2 || MODULUS > (64'sd1 <<< WIDTH)) begin : g_bad_mod
            $error("tff_counter_param: MODULUS out of range");
        end
        if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_rst
            $error("tff_counter_param: RESET_VAL must be below MODULUS");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RSTV = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;

    logic run_tff, run_up, run_dn;
    assign run_tff = !load && en && !mode;
    assign run_up  = !load && en && mode && up;
    assign run_dn  = !load && en && mode && !up;

    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        unique case (1'b1)
            load: begin
                if (mode && (d > MAXV)) q_d = MAXV;
                else                    q_d = d;
            end
            run_tff: q_d = q_q ^ t;
            run_up: begin
                if (q_q >= MAXV) begin
                    q_d  = '0;
                    tc_d = 1'b1;
                end else begin
                    q_d = q_q + WIDTH'(1);
                end
            end
            run_dn: begin
                // A value above the range (left by T-FF mode) snaps to the top without a wrap.
                if (q_q == '0) begin
                    q_d  = MAXV;
                    tc_d = 1'b1;
                end else if (q_q > MAXV) begin
                    q_d = MAXV;
                end else begin
                    q_d = q_q - WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q  <= RSTV;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    assign q    = q_q;
    assign qbar = ~q_q;
    assign tc   = tc_q;

endmodule
